reimu_bullet_pool: RTL and testbench

REIMU_BULLET_POOL -- requirements
Module: reimu_bullet_pool

---
 rtl/reimu_bullet_pool.sv | 198 +++++++++++++++++++
 tb/tb_reimu_bullet_pool.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reimu_bullet_pool.sv
// Player bullet pool. Fixed array of bullet slots that spawn at the player
// position, move up on each tick, and retire at the top edge. When
// BOSS_HIT_EN is defined they also retire when they collide with the boss.
// bullet_pix is a registered per-pixel coverage flag used by the renderer.
//
// Optional feature macro: BOSS_HIT_EN. When it is defined, boss collision,
// the hit pulse and the hit counter are built. When it is undefined, no
// collision logic is built and hit/hit_cnt stay 0.
//
// Ports
//   clk            system clock
//   rst            asynchronous reset, active low
//   tick           one-cycle movement strobe; all state updates happen on it
//   shoot          fire request, level sensitive
//   reimux/reimuy  player top-left position (spawn origin)
//   bossx/bossy    boss top-left position
//   hc/vc          current VGA pixel coordinates
//   bullet_pix     current pixel lies inside an active bullet (1 clk latency)
//   active_cnt     number of valid slots
//   drop           pulse: spawn refused because the pool is full
//   hit            pulse: at least one bullet hit the boss on this tick
//   hit_cnt        saturating count of bullets that hit the boss
module reimu_bullet_pool #(
    parameter int NUM_SLOTS = 8,
    parameter int SPEED     = 4,
    parameter int COOLDOWN  = 3,
    parameter int BW        = 4,
    parameter int BH        = 8,
    parameter int BOSS_W    = 64,
    parameter int BOSS_H    = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       shoot,
    input  logic [9:0] reimux,
    input  logic [9:0] reimuy,
    input  logic [9:0] bossx,
    input  logic [9:0] bossy,
    input  logic [9:0] hc,
    input  logic [9:0] vc,
    output logic       bullet_pix,
    output logic [4:0] active_cnt,
    output logic       drop,
    output logic       hit,
    output logic [7:0] hit_cnt
);

    localparam int IDX_W = $clog2(NUM_SLOTS);
    localparam int CD_W  = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);

    logic [NUM_SLOTS-1:0] valid_q, valid_d;
    logic [9:0]           x_q [NUM_SLOTS];
    logic [9:0]           x_d [NUM_SLOTS];
    logic [9:0]           y_q [NUM_SLOTS];
    logic [9:0]           y_d [NUM_SLOTS];
    logic [CD_W-1:0]      cd_q, cd_d;
    logic                 pix_q, pix_d;
    logic [4:0]           act_q, act_d;
    logic                 drop_q, drop_d;
    logic                 hit_q, hit_d;
    logic [7:0]           hit_cnt_q, hit_cnt_d;

    logic [NUM_SLOTS-1:0] hit_vec;
    logic [4:0]           hit_n;
    logic [8:0]           hit_sum;
    logic                 have_free;
    logic [IDX_W-1:0]     free_idx;

    // Box ends are 11 bits wide so boxes near 1023 cannot wrap.
    function automatic logic [10:0] box_end(input logic [9:0] org, input int len);
        return {1'b0, org} + 11'(len) - 11'd1;
    endfunction

    function automatic logic covers(input logic [9:0] ox, input logic [9:0] oy,
                                    input logic [9:0] px, input logic [9:0] py);
        return ({1'b0, px} >= {1'b0, ox}) && ({1'b0, px} <= box_end(ox, BW)) &&
               ({1'b0, py} >= {1'b0, oy}) && ({1'b0, py} <= box_end(oy, BH));
    endfunction

`ifdef BOSS_HIT_EN
    function automatic logic overlaps(input logic [9:0] ox, input logic [9:0] oy,
                                      input logic [9:0] bx, input logic [9:0] by);
        return ({1'b0, ox} <= box_end(bx, BOSS_W)) && ({1'b0, bx} <= box_end(ox, BW)) &&
               ({1'b0, oy} <= box_end(by, BOSS_H)) && ({1'b0, by} <= box_end(oy, BH));
    endfunction

    always_comb begin
        hit_vec = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            hit_vec[i] = valid_q[i] && overlaps(x_q[i], y_q[i], bossx, bossy);
        end
    end
`else
    logic unused_boss;
    assign unused_boss = ^{bossx, bossy};
    assign hit_vec     = '0;
`endif

    // Lowest-index slot that is free before this tick; slots retiring on
    // the same tick are not seen as free until the next tick.
    always_comb begin
        have_free = 1'b0;
        free_idx  = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                have_free = 1'b1;
                free_idx  = IDX_W'(i);
            end
        end
    end

    always_comb begin
        act_d = '0;
        hit_n = '0;
        pix_d = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            act_d = act_d + 5'(valid_q[i]);
            hit_n = hit_n + 5'(hit_vec[i]);
            if (valid_q[i] && covers(x_q[i], y_q[i], hc, vc)) begin
                pix_d = 1'b1;
            end
        end
    end

    assign hit_sum = {1'b0, hit_cnt_q} + {4'b0, hit_n};

    always_comb begin
        valid_d   = valid_q;
        x_d       = x_q;
        y_d       = y_q;
        cd_d      = cd_q;
        drop_d    = 1'b0;
        hit_d     = 1'b0;
        hit_cnt_d = hit_cnt_q;
        if (tick) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (valid_q[i]) begin
                    if (hit_vec[i]) begin
                        valid_d[i] = 1'b0;
                    end else if (y_q[i] < 10'(SPEED)) begin
                        valid_d[i] = 1'b0;
                    end else begin
                        y_d[i] = y_q[i] - 10'(SPEED);
                    end
                end
            end
            if (shoot && (cd_q == '0)) begin
                if (have_free) begin
                    valid_d[free_idx] = 1'b1;
                    x_d[free_idx]     = reimux;
                    y_d[free_idx]     = reimuy;
                    cd_d              = CD_W'(COOLDOWN);
                end else begin
                    // Pool full: refuse without reloading, so the next tick retries.
                    drop_d = 1'b1;
                end
            end else if (cd_q != '0) begin
                cd_d = cd_q - CD_W'(1);
            end
            hit_d     = |hit_vec;
            hit_cnt_d = hit_sum[8] ? 8'hFF : hit_sum[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
            cd_q      <= '0;
            pix_q     <= 1'b0;
            act_q     <= '0;
            drop_q    <= 1'b0;
            hit_q     <= 1'b0;
            hit_cnt_q <= '0;
        end else begin
            valid_q   <= valid_d;
            x_q       <= x_d;
            y_q       <= y_d;
            cd_q      <= cd_d;
            pix_q     <= pix_d;
            act_q     <= act_d;
            drop_q    <= drop_d;
            hit_q     <= hit_d;
            hit_cnt_q <= hit_cnt_d;
        end
    end

    assign bullet_pix = pix_q;
    assign active_cnt = act_q;
    assign drop       = drop_q;
    assign hit        = hit_q;
    assign hit_cnt    = hit_cnt_q;

endmodule

// File: tb/tb_reimu_bullet_pool.sv
module tb_reimu_bullet_pool;

`ifdef BOSS_HIT_EN
    localparam bit HIT_EN = 1'b1;
`else
    localparam bit HIT_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       tick;
    logic       shoot;
    logic [9:0] reimux, reimuy, bossx, bossy, hc, vc;
    logic       bullet_pix;
    logic [4:0] active_cnt;
    logic       drop;
    logic       hit;
    logic [7:0] hit_cnt;

    reimu_bullet_pool dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .shoot      (shoot),
        .reimux     (reimux),
        .reimuy     (reimuy),
        .bossx      (bossx),
        .bossy      (bossy),
        .hc         (hc),
        .vc         (vc),
        .bullet_pix (bullet_pix),
        .active_cnt (active_cnt),
        .drop       (drop),
        .hit        (hit),
        .hit_cnt    (hit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int    due;
        int    kind;
        int    exp;
        string name;
    } exp_t;

    exp_t sbq[$];
    exp_t rstq[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Bench-side shooting model state
    int mcd  = 0;
    int mcnt = 0;

    function automatic int get_val(input int kind);
        case (kind)
            0:       return int'(active_cnt);
            1:       return int'(bullet_pix);
            2:       return int'(drop);
            3:       return int'(hit);
            default: return int'(hit_cnt);
        endcase
    endfunction

    task automatic check(input exp_t e);
        int act;
        act = get_val(e.kind);
        n_checks++;
        if (act != e.exp) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", e.name, cyc, act, e.exp);
        end
    endtask

    // Monitor: compares each scheduled expectation when its cycle arrives.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sbq.size() > 0 && sbq[0].due <= cyc) begin
                e = sbq.pop_front();
                check(e);
            end
        end
    end

    // Reset monitor: outputs must clear without waiting for a clock edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge rst);
            #1;
            while (rstq.size() > 0) begin
                e = rstq.pop_front();
                check(e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic void expect_at(input int d, input int kind, input int v, input string nm);
        exp_t e;
        e.due  = cyc + d;
        e.kind = kind;
        e.exp  = v;
        e.name = nm;
        sbq.push_back(e);
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_reset();
        idle(2);
        rst = 1'b0;
        @(negedge clk);
        rst  = 1'b1;
        mcd  = 0;
        mcnt = 0;
    endtask

    task automatic tick_once(input bit sh, input int e_drop, input int e_hit,
                             input int e_hcnt, input int e_act);
        shoot = sh;
        tick  = 1'b1;
        expect_at(1, 2, e_drop, "drop");
        expect_at(1, 3, e_hit, "hit");
        expect_at(1, 4, e_hcnt, "hit_cnt");
        expect_at(2, 0, e_act, "active_cnt");
        @(negedge clk);
        tick  = 1'b0;
        shoot = 1'b0;
    endtask

    // Continuous fire with no bullet ever leaving (player low on screen).
    task automatic shoot_run(input int n);
        int ed;
        for (int k = 0; k < n; k++) begin
            ed = 0;
            if (mcd == 0) begin
                if (mcnt < 8) begin
                    mcnt++;
                    mcd = 3;
                end else begin
                    ed = 1;
                end
            end else begin
                mcd--;
            end
            tick_once(1'b1, ed, 0, 0, mcnt);
        end
    endtask

    task automatic probe(input int h, input int v, input int e);
        hc = 10'(h);
        vc = 10'(v);
        expect_at(1, 1, e, $sformatf("bullet_pix(%0d,%0d)", h, v));
        @(negedge clk);
    endtask

    initial begin
        int   y, hcnt;
        bit   vld, h;
        exp_t e;

        rst    = 1'b0;
        tick   = 1'b0;
        shoot  = 1'b0;
        reimux = '0;
        reimuy = '0;
        bossx  = 10'd900;
        bossy  = 10'd0;
        hc     = '0;
        vc     = '0;
        idle(3);
        rst = 1'b1;

        // Reset state
        expect_at(1, 0, 0, "rst active_cnt");
        expect_at(1, 1, 0, "rst bullet_pix");
        expect_at(1, 2, 0, "rst drop");
        expect_at(1, 3, 0, "rst hit");
        expect_at(1, 4, 0, "rst hit_cnt");
        idle(2);

        // Spawn at (300,400), then 10 moves -> y = 360
        reimux = 10'd300;
        reimuy = 10'd400;
        tick_once(1'b1, 0, 0, 0, 1);
        for (int k = 0; k < 10; k++) tick_once(1'b0, 0, 0, 0, 1);
        probe(300, 360, 1);
        probe(299, 360, 0);
        probe(300, 359, 0);
        probe(303, 367, 1);
        probe(304, 367, 0);
        probe(300, 368, 0);

        // Continuous fire: one spawn every 4th tick, fill to 8, then drop
        do_reset();
        reimux = 10'd200;
        reimuy = 10'd400;
        shoot_run(40);
        probe(200, 244, 1);
        probe(200, 243, 0);
        probe(200, 400, 0);

        // Top edge retirement
        do_reset();
        reimux = 10'd50;
        reimuy = 10'd5;
        tick_once(1'b1, 0, 0, 0, 1);
        tick_once(1'b0, 0, 0, 0, 1);
        probe(50, 1, 1);
        probe(50, 0, 0);
        probe(53, 8, 1);
        tick_once(1'b0, 0, 0, 0, 0);
        probe(50, 1, 0);

        // Boss collision (or pass-through when collision is not built)
        do_reset();
        bossx  = 10'd280;
        bossy  = 10'd300;
        reimux = 10'd300;
        reimuy = 10'd400;
        tick_once(1'b1, 0, 0, 0, 1);
        y    = 400;
        vld  = 1'b1;
        hcnt = 0;
        for (int k = 1; k <= 12; k++) begin
            h = HIT_EN && vld && (y <= 363) && (y + 7 >= 300);
            if (vld) begin
                if (h) begin
                    vld = 1'b0;
                    hcnt++;
                end else if (y < 4) begin
                    vld = 1'b0;
                end else begin
                    y -= 4;
                end
            end
            tick_once(1'b0, 0, int'(h), hcnt, int'(vld));
        end
        probe(300, y, int'(vld));
        bossx = 10'd900;
        bossy = 10'd0;

        // Pixel coverage sweep around a bullet at (100,50)
        do_reset();
        reimux = 10'd100;
        reimuy = 10'd50;
        tick_once(1'b1, 0, 0, 0, 1);
        idle(1);
        for (int x = 98; x <= 105; x++) probe(x, 53, int'(x >= 100 && x <= 103));
        for (int v = 48; v <= 59; v++) probe(101, v, int'(v >= 50 && v <= 57));
        probe(103, 57, 1);
        probe(104, 58, 0);

        // Asynchronous reset mid-cycle with 5 bullets in flight
        do_reset();
        reimux = 10'd200;
        reimuy = 10'd400;
        shoot_run(17);
        probe(200, 400, 1);
        idle(3);
        for (int k = 0; k < 5; k++) begin
            e.due  = 0;
            e.kind = k;
            e.exp  = 0;
            e.name = $sformatf("async_rst kind%0d", k);
            rstq.push_back(e);
        end
        #2;
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst  = 1'b1;
        mcd  = 0;
        mcnt = 0;
        shoot_run(1);
        probe(200, 400, 1);
        probe(200, 384, 0);

        idle(3);
        if (sbq.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
